axi4_slave_mem: RTL and testbench

Single-beat AXI4 slave responder backed by an internal word-addressed register file. It is the responder end of the `axi4_if` channel set: it accepts write address and write data in either order, commits the write and returns a B response, and accepts read addresses, returning R data tagged with the request ID. It serves as the DUT-side memory target for the AXI4 master and as a reference slave in the UVM environment.

---
 rtl/axi4_slave_mem_if.sv | 38 +++
 rtl/axi4_slave_mem.sv | 172 +++++++++++++++++
 tb/tb_axi4_slave_mem.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/axi4_slave_mem_if.sv
// AXI4 single-beat channel bundle between a master and the memory slave.
// Clock and reset are carried separately as plain ports.
interface axi4_slave_mem_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  awvalid;
   logic                  awready;
   logic [DATA_WIDTH-1:0] awaddr;
   logic                  wvalid;
   logic                  wready;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  bvalid;
   logic [2:0]            bresp;
   logic                  bready;
   logic                  arvalid;
   logic                  arready;
   logic [2:0]            arid;
   logic [DATA_WIDTH-1:0] araddr;
   logic                  rvalid;
   logic                  rready;
   logic [2:0]            rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [2:0]            rresp;

   modport master (
      output awvalid, awaddr, wvalid, wdata, bready,
      output arvalid, arid, araddr, rready,
      input  awready, wready, bvalid, bresp,
      input  arready, rvalid, rid, rdata, rresp
   );

   modport slave (
      input  awvalid, awaddr, wvalid, wdata, bready,
      input  arvalid, arid, araddr, rready,
      output awready, wready, bvalid, bresp,
      output arready, rvalid, rid, rdata, rresp
   );
endinterface

// File: rtl/axi4_slave_mem.sv
// Single-beat AXI4 slave backed by a word-addressed register file.
// Independent write (AW/W in any order) and read FSMs; all outputs registered.
module axi4_slave_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 16
) (
   input logic              clk_i,
   input logic              aresetn,
   axi4_slave_mem_if.slave  bus
);
   localparam int OFF = (DATA_WIDTH == 64) ? 3 : 2;
   localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int HW  = DATA_WIDTH - OFF;
   localparam logic [2:0] OKAY   = 3'b000;
   localparam logic [2:0] SLVERR = 3'b010;

   typedef logic [DATA_WIDTH-1:0] word_t;

   typedef enum logic [1:0] {
      W_IDLE, W_AW, W_W, W_RESP
   } wstate_e;

   typedef enum logic {
      R_IDLE, R_DATA
   } rstate_e;

   word_t   mem_q [DEPTH];

   wstate_e wst_q;
   logic    awready_q, wready_q, bvalid_q;
   logic [2:0] bresp_q;
   word_t   awaddr_q, wdata_q;

   rstate_e rst_q;
   logic    arready_q, rvalid_q;
   logic [2:0] rid_q, rresp_q;
   word_t   rdata_q;

   logic    aw_hs, w_hs, ar_hs, commit_d;
   word_t   waddr_d, wdata_d;
   logic [HW-1:0] whi, rhi;
   logic    w_ok, r_ok;
   logic [IW-1:0] w_idx, r_idx;

   assign aw_hs = bus.awvalid & awready_q;
   assign w_hs  = bus.wvalid & wready_q;
   assign ar_hs = bus.arvalid & arready_q;

   // Pick the address/data source for the beat that completes the pair
   always_comb begin
      commit_d = 1'b0;
      waddr_d  = awaddr_q;
      wdata_d  = wdata_q;
      unique case (wst_q)
         W_IDLE: begin
            commit_d = aw_hs & w_hs;
            waddr_d  = bus.awaddr;
            wdata_d  = bus.wdata;
         end
         W_AW: begin
            commit_d = w_hs;
            wdata_d  = bus.wdata;
         end
         W_W: begin
            commit_d = aw_hs;
            waddr_d  = bus.awaddr;
         end
         default: ;
      endcase
   end

   assign whi   = waddr_d[DATA_WIDTH-1:OFF];
   assign w_ok  = (waddr_d[OFF-1:0] == '0) && ((whi >> IW) == '0);
   assign w_idx = whi[IW-1:0];

   assign rhi   = bus.araddr[DATA_WIDTH-1:OFF];
   assign r_ok  = (bus.araddr[OFF-1:0] == '0) && ((rhi >> IW) == '0);
   assign r_idx = rhi[IW-1:0];

   always_ff @(posedge clk_i) begin
      if (!aresetn) begin
         wst_q     <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= OKAY;
         awaddr_q  <= '0;
         wdata_q   <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (commit_d) begin
         if (w_ok) mem_q[w_idx] <= wdata_d;
         bresp_q   <= w_ok ? OKAY : SLVERR;
         bvalid_q  <= 1'b1;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         wst_q     <= W_RESP;
      end else begin
         unique case (wst_q)
            W_IDLE: begin
               if (aw_hs) begin
                  awaddr_q  <= bus.awaddr;
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  wst_q     <= W_AW;
               end else if (w_hs) begin
                  wdata_q   <= bus.wdata;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b0;
                  wst_q     <= W_W;
               end else begin
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
               end
            end
            W_RESP: begin
               if (bus.bready) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  wready_q  <= 1'b1;
                  wst_q     <= W_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   // Read sees the pre-edge memory, so a same-edge write returns old data
   always_ff @(posedge clk_i) begin
      if (!aresetn) begin
         rst_q     <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rid_q     <= '0;
         rresp_q   <= OKAY;
         rdata_q   <= '0;
      end else begin
         unique case (rst_q)
            R_IDLE: begin
               if (ar_hs) begin
                  rdata_q   <= r_ok ? mem_q[r_idx] : '0;
                  rresp_q   <= r_ok ? OKAY : SLVERR;
                  rid_q     <= bus.arid;
                  rvalid_q  <= 1'b1;
                  arready_q <= 1'b0;
                  rst_q     <= R_DATA;
               end else begin
                  arready_q <= 1'b1;
               end
            end
            R_DATA: begin
               if (bus.rready) begin
                  rvalid_q  <= 1'b0;
                  arready_q <= 1'b1;
                  rst_q     <= R_IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.awready = awready_q;
   assign bus.wready  = wready_q;
   assign bus.bvalid  = bvalid_q;
   assign bus.bresp   = bresp_q;
   assign bus.arready = arready_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.rid     = rid_q;
   assign bus.rdata   = rdata_q;
   assign bus.rresp   = rresp_q;
endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed bench for axi4_slave_mem: reset, ordering, backpressure,
// error responses, same-edge read/write and reset mid-response.
module tb_axi4_slave_mem;
   logic clk_i;
   logic aresetn;
   int   errors;
   int   checks;

   axi4_slave_mem_if #(.DATA_WIDTH(32)) bus ();

   axi4_slave_mem #(
      .DATA_WIDTH (32),
      .DEPTH      (16)
   ) dut (
      .clk_i   (clk_i),
      .aresetn (aresetn),
      .bus     (bus)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic aw_w(input logic [31:0] a, input logic [31:0] d);
      bus.awvalid = 1'b1; bus.awaddr = a;
      bus.wvalid  = 1'b1; bus.wdata  = d;
      step();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
   endtask

   task automatic ar(input logic [31:0] a, input logic [2:0] id);
      bus.arvalid = 1'b1; bus.araddr = a; bus.arid = id;
      step();
      bus.arvalid = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      aresetn     = 1'b0;
      bus.awvalid = 1'b1; bus.awaddr = 32'h0;
      bus.wvalid  = 1'b0; bus.wdata  = 32'h0;
      bus.bready  = 1'b1;
      bus.arvalid = 1'b0; bus.araddr = 32'h0; bus.arid = 3'd0;
      bus.rready  = 1'b1;

      // reset held 3 cycles with awvalid high
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_awready", bus.awready, 0);
         chk("rst_wready",  bus.wready,  0);
         chk("rst_arready", bus.arready, 0);
         chk("rst_bvalid",  bus.bvalid,  0);
         chk("rst_rvalid",  bus.rvalid,  0);
         chk("rst_bresp",   bus.bresp,   0);
         chk("rst_rresp",   bus.rresp,   0);
         chk("rst_rid",     bus.rid,     0);
         chk("rst_rdata",   bus.rdata,   0);
      end
      aresetn = 1'b1;
      step();
      chk("rel_awready", bus.awready, 1);
      chk("rel_wready",  bus.wready,  1);
      chk("rel_arready", bus.arready, 1);
      chk("rel_bvalid",  bus.bvalid,  0);
      bus.awvalid = 1'b0;

      // write then read back
      aw_w(32'h8, 32'hDEADBEEF);
      chk("w8_bvalid",  bus.bvalid,  1);
      chk("w8_bresp",   bus.bresp,   0);
      chk("w8_awready", bus.awready, 0);
      step();
      chk("w8_bdone",   bus.bvalid,  0);
      chk("w8_awrdy",   bus.awready, 1);
      ar(32'h8, 3'd5);
      chk("r8_rvalid",  bus.rvalid,  1);
      chk("r8_rdata",   bus.rdata,   32'hDEADBEEF);
      chk("r8_rid",     bus.rid,     5);
      chk("r8_rresp",   bus.rresp,   0);
      chk("r8_arready", bus.arready, 0);
      step();
      chk("r8_rdone",   bus.rvalid,  0);
      chk("r8_arrdy",   bus.arready, 1);

      // W three cycles ahead of AW, then B backpressure
      bus.bready = 1'b0;
      bus.wvalid = 1'b1; bus.wdata = 32'h12345678;
      step();
      bus.wvalid = 1'b0;
      chk("ooo_wready",  bus.wready,  0);
      chk("ooo_awready", bus.awready, 1);
      chk("ooo_bvalid0", bus.bvalid,  0);
      step();
      step();
      bus.awvalid = 1'b1; bus.awaddr = 32'h4;
      step();
      bus.awvalid = 1'b0;
      chk("ooo_bvalid", bus.bvalid, 1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("bp_bvalid",  bus.bvalid,  1);
         chk("bp_bresp",   bus.bresp,   0);
         chk("bp_awready", bus.awready, 0);
         chk("bp_wready",  bus.wready,  0);
      end
      bus.bready = 1'b1;
      step();
      chk("bp_bdone",  bus.bvalid, 0);
      chk("bp_wrdy",   bus.wready, 1);
      ar(32'h4, 3'd2);
      chk("r4_rdata", bus.rdata, 32'h12345678);
      chk("r4_rid",   bus.rid,   2);
      step();

      // error responses
      aw_w(32'h40, 32'hFFFFFFFF);
      chk("e40_bresp", bus.bresp, 3'b010);
      step();
      aw_w(32'h2, 32'hAAAAAAAA);
      chk("e2_bresp", bus.bresp, 3'b010);
      step();
      ar(32'h0, 3'd1);
      chk("r0_rdata", bus.rdata, 0);
      chk("r0_rresp", bus.rresp, 0);
      step();
      ar(32'h40, 3'd7);
      chk("r40_rresp", bus.rresp, 3'b010);
      chk("r40_rdata", bus.rdata, 0);
      chk("r40_rid",   bus.rid,   7);
      step();

      // same-edge commit and read to one index
      aw_w(32'hC, 32'h1);
      step();
      bus.arvalid = 1'b1; bus.araddr = 32'hC; bus.arid = 3'd3;
      aw_w(32'hC, 32'h2);
      bus.arvalid = 1'b0;
      chk("cc_bvalid", bus.bvalid, 1);
      chk("cc_rvalid", bus.rvalid, 1);
      chk("cc_rdata",  bus.rdata,  32'h1);
      step();
      ar(32'hC, 3'd4);
      chk("cc_rdata2", bus.rdata, 32'h2);
      step();

      // reset while both responses are pending
      bus.bready = 1'b0;
      bus.rready = 1'b0;
      bus.arvalid = 1'b1; bus.araddr = 32'h4; bus.arid = 3'd6;
      aw_w(32'h8, 32'h55);
      bus.arvalid = 1'b0;
      chk("mr_bvalid1", bus.bvalid, 1);
      chk("mr_rvalid1", bus.rvalid, 1);
      aresetn = 1'b0;
      step();
      chk("mr_bvalid0", bus.bvalid, 0);
      chk("mr_rvalid0", bus.rvalid, 0);
      chk("mr_rdata0",  bus.rdata,  0);
      aresetn = 1'b1;
      bus.bready = 1'b1;
      bus.rready = 1'b1;
      step();
      chk("mr_arready", bus.arready, 1);
      ar(32'h8, 3'd1);
      chk("mr_r8", bus.rdata, 0);
      step();
      ar(32'h4, 3'd1);
      chk("mr_r4", bus.rdata, 0);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
